// File: rtl/primo_prefetch_if.sv
// -----------------------------------------------------------------------------
// primo_prefetch_if
// Bundles every handshake and data signal around primo_prefetch: the control
// link to one primogen core and the FIFO read port seen by the consumer.
//
// Signals (W = 1 << WIDTH_LOG):
//   en        prefetch enable from board logic
//   pg_go     one-cycle start pulse to primogen
//   pg_ready  primogen ready
//   pg_error  primogen error
//   pg_res    primogen result [W-1:0]
//   valid     FIFO non-empty
//   data      FIFO head, first-word-fall-through [W-1:0]
//   pop       consume FIFO head
//   err       sticky error flag
//   level     stored entry count [DEPTH_LOG:0]
//
// Modports:
//   master  the prefetch controller
//   slave   the surrounding environment (primogen core plus consumer)
// -----------------------------------------------------------------------------
interface primo_prefetch_if #(
   parameter int WIDTH_LOG = 4,
   parameter int DEPTH_LOG = 2
) ();
   localparam int W = 1 << WIDTH_LOG;

   logic             en;
   logic             pg_go;
   logic             pg_ready;
   logic             pg_error;
   logic [W-1:0]     pg_res;
   logic             valid;
   logic [W-1:0]     data;
   logic             pop;
   logic             err;
   logic [DEPTH_LOG:0] level;

   modport master (
      input  en, pg_ready, pg_error, pg_res, pop,
      output pg_go, valid, data, err, level
   );

   modport slave (
      output en, pg_ready, pg_error, pg_res, pop,
      input  pg_go, valid, data, err, level
   );
endinterface

// File: rtl/primo_prefetch.sv
// -----------------------------------------------------------------------------
// primo_prefetch
// Sequences one primogen core and buffers its results in a small FIFO so a
// consumer can pop primes with single-cycle latency. A new search is started
// only when a FIFO slot can be reserved for its result, so a push never lands
// on a full FIFO.
//
// Ports:
//   clk      single clock
//   rst      asynchronous, active-high reset (primogen must share it)
//   bus      primo_prefetch_if.master: en, pg_go, pg_ready, pg_error, pg_res,
//            valid, data, pop, err, level
//
// Optional feature, macro PRIMO_PREFETCH_STATS_EN:
//   issued   [31:0] saturating count of pg_go pulses since reset
//   stalls   [31:0] saturating count of IDLE cycles with en=1 and FIFO full
// -----------------------------------------------------------------------------
module primo_prefetch #(
   parameter int WIDTH_LOG = 4,
   parameter int DEPTH_LOG = 2
) (
   input  logic             clk,
   input  logic             rst,
   primo_prefetch_if.master bus
`ifdef PRIMO_PREFETCH_STATS_EN
   ,
   output logic [31:0]      issued,
   output logic [31:0]      stalls
`endif
);
   localparam int W     = 1 << WIDTH_LOG;
   localparam int DEPTH = 1 << DEPTH_LOG;
   // A depth-1 FIFO still gets a one-bit pointer that simply never moves.
   localparam int AW    = (DEPTH_LOG > 0) ? DEPTH_LOG : 1;
   localparam int LW    = DEPTH_LOG + 1;

   localparam logic [LW:0]   DEPTH_OCC = (LW + 1)'(DEPTH);
   localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      SKIP  = 3'd2,
      WAIT  = 3'd3,
      HALT  = 3'd4
   } state_t;

   // Modulo-DEPTH pointer increment (DEPTH is a power of two but may be 1).
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      logic [AW-1:0] r;
      if (p == PTR_LAST) begin
         r = {AW{1'b0}};
      end else begin
         r = p + AW'(1);
      end
      return r;
   endfunction

   state_t          state_q, state_d;
   logic            pending_q, pending_d;
   logic            pg_go_q, pg_go_d;
   logic            err_q, err_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            valid_q, valid_d;
   logic [W-1:0]    data_q, data_d;
   logic [W-1:0]    mem_q [DEPTH];
   logic [W-1:0]    mem_d [DEPTH];

   logic            push;
   logic            pop_ok;
   logic [LW:0]     occ;

   // Stored entries plus the slot reserved for an in-flight search.
   assign occ = {1'b0, level_q} + {{LW{1'b0}}, pending_q};

   // Next-state decode, slot reservation and sticky error capture
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      err_d     = err_q;
      push      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.pg_error) begin
               state_d = HALT;
               err_d   = 1'b1;
            end else if (bus.en && bus.pg_ready && !err_q && (occ < DEPTH_OCC)) begin
               state_d   = ISSUE;
               pending_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: state_d = SKIP;
         // primogen registers go late, so its ready is stale for one cycle.
         SKIP:  state_d = WAIT;
         WAIT: begin
            if (bus.pg_ready) begin
               pending_d = 1'b0;
               if (bus.pg_error) begin
                  err_d   = 1'b1;
                  state_d = HALT;
               end else begin
                  push    = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               state_d = WAIT;
            end
         end
         HALT: state_d = HALT;
         default: begin
            state_d   = IDLE;
            pending_d = 1'b0;
         end
      endcase
      // go is registered so it is high exactly while the FSM sits in ISSUE.
      pg_go_d = (state_d == ISSUE);
   end

   // FIFO pointers, storage, occupancy and first-word-fall-through head
   always_comb begin
      pop_ok   = bus.pop && valid_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = bus.pg_res;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      valid_d = (level_d != {LW{1'b0}});
      // Head is taken from next-cycle storage so a push into an empty FIFO
      // (or a push+pop at level 1) shows up on data right after the edge.
      if (valid_d) begin
         data_d = mem_d[rd_ptr_d];
      end else begin
         data_d = {W{1'b0}};
      end
   end

   // State and FIFO registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         pg_go_q   <= 1'b0;
         err_q     <= 1'b0;
         wr_ptr_q  <= {AW{1'b0}};
         rd_ptr_q  <= {AW{1'b0}};
         level_q   <= {LW{1'b0}};
         valid_q   <= 1'b0;
         data_q    <= {W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {W{1'b0}};
         end
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         pg_go_q   <= pg_go_d;
         err_q     <= err_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         mem_q     <= mem_d;
      end
   end

   assign bus.pg_go = pg_go_q;
   assign bus.valid = valid_q;
   assign bus.data  = data_q;
   assign bus.err   = err_q;
   assign bus.level = level_q;

`ifdef PRIMO_PREFETCH_STATS_EN
   logic [31:0] issued_q, issued_d;
   logic [31:0] stalls_q, stalls_d;

   // Saturating issue and full-stall counters
   always_comb begin
      issued_d = issued_q;
      stalls_d = stalls_q;
      if (pg_go_d && (issued_q != 32'hFFFF_FFFF)) begin
         issued_d = issued_q + 32'd1;
      end else begin
         issued_d = issued_q;
      end
      if ((state_q == IDLE) && bus.en && (occ == DEPTH_OCC) &&
          (stalls_q != 32'hFFFF_FFFF)) begin
         stalls_d = stalls_q + 32'd1;
      end else begin
         stalls_d = stalls_q;
      end
   end

   // Statistics registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued_q <= 32'd0;
         stalls_q <= 32'd0;
      end else begin
         issued_q <= issued_d;
         stalls_q <= stalls_d;
      end
   end

   assign issued = issued_q;
   assign stalls = stalls_q;
`endif
endmodule

// File: tb/tb_primo_prefetch.sv
// -----------------------------------------------------------------------------
// tb_primo_prefetch
// Directed bench for primo_prefetch (W = 16, DEPTH = 4) driving a behavioural
// primogen with a 10-cycle search that yields 2, 3, 5, 7, 11, ...
// Expected pop values are queued by the stimulus; a separate monitor compares
// them whenever the consumer pops a valid head.
// Build with PRIMO_PREFETCH_STATS_EN to also exercise the counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_primo_prefetch;
   logic clk = 1'b0;
   logic rst = 1'b1;

   primo_prefetch_if #(.WIDTH_LOG(4), .DEPTH_LOG(2)) bus ();

`ifdef PRIMO_PREFETCH_STATS_EN
   logic [31:0] issued;
   logic [31:0] stalls;
`endif

   primo_prefetch #(.WIDTH_LOG(4), .DEPTH_LOG(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef PRIMO_PREFETCH_STATS_EN
      ,
      .issued (issued),
      .stalls (stalls)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int exp_q[$];
   int go_cnt;
   int err_on = 0;

   // ---------------- behavioural primogen ----------------
   int   primes [12] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37};
   logic m_busy;
   logic m_err;
   int   m_cnt;
   int   m_idx;
   int   m_search;

   assign bus.pg_ready = ~m_busy;
   assign bus.pg_error = m_err;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy     <= 1'b0;
         m_err      <= 1'b0;
         m_cnt      <= 0;
         m_idx      <= 0;
         m_search   <= 0;
         bus.pg_res <= 16'd0;
      end else if (m_busy) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_busy <= 1'b0;
            if (err_on != 0 && m_search == err_on) begin
               m_err <= 1'b1;
            end else begin
               bus.pg_res <= 16'(primes[m_idx]);
               m_idx      <= m_idx + 1;
            end
         end
      end else if (bus.pg_go) begin
         m_busy   <= 1'b1;
         m_cnt    <= 10;
         m_search <= m_search + 1;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) go_cnt <= 0;
      else if (bus.pg_go) go_cnt <= go_cnt + 1;
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst && bus.pop && bus.valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pop_data actual=%0d expected=<none queued>", bus.data);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(bus.data) != e) begin
               failures++;
               $display("FAIL pop_data actual=%0d expected=%0d", bus.data, e);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic wait_level(input int n, input int budget, input string tag);
      int k = 0;
      while (int'(bus.level) != n && k < budget) begin
         cyc();
         k++;
      end
      chk(tag, 32'(bus.level), 32'(n));
   endtask

   task automatic wait_ready(input logic v, input int budget, input string tag);
      int k = 0;
      while (bus.pg_ready !== v && k < budget) begin
         cyc();
         k++;
      end
      chk(tag, 32'(bus.pg_ready), 32'(v));
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      bus.en  = 1'b0;
      bus.pop = 1'b0;
      exp_q.delete();
      cyc();
      cyc();
      chk("rst_pg_go", 32'(bus.pg_go), 32'd0);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_data",  32'(bus.data),  32'd0);
      chk("rst_err",   32'(bus.err),   32'd0);
      chk("rst_level", 32'(bus.level), 32'd0);
      rst = 1'b0;
      cyc();
   endtask

   task automatic pop_n(input int n);
      bus.pop = 1'b1;
      repeat (n) cyc();
      bus.pop = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.en  = 1'b0;
      bus.pop = 1'b0;

      // Fill: four searches, FIFO full, then no further go
      do_reset();
      bus.en = 1'b1;
      wait_level(4, 300, "fill_level");
      chk("fill_go_cnt", 32'(go_cnt), 32'd4);
      chk("fill_data", 32'(bus.data), 32'd2);
      chk("fill_valid", 32'(bus.valid), 32'd1);
`ifdef PRIMO_PREFETCH_STATS_EN
      begin
         logic [31:0] s0;
         chk("stats_issued", issued, 32'd4);
         s0 = stalls;
         cyc();
         chk("stats_stall_inc", stalls, s0 + 32'd1);
      end
`endif
      repeat (200) cyc();
      chk("fill_no_more_go", 32'(go_cnt), 32'd4);

      // Drain/refill: one pop from full re-arms issue, 11 refills the FIFO
      exp_q.push_back(2);
      exp_q.push_back(3);
      exp_q.push_back(5);
      exp_q.push_back(7);
      exp_q.push_back(11);
      pop_n(1);
      chk("pop_next_data", 32'(bus.data), 32'd3);
      chk("pop_level", 32'(bus.level), 32'd3);
      chk("pop_go_early", 32'(bus.pg_go), 32'd0);
      cyc();
      chk("pop_go_fires", 32'(bus.pg_go), 32'd1);
      wait_level(4, 100, "refill_level");
      chk("refill_head", 32'(bus.data), 32'd3);
      pop_n(4);
      chk("drain_valid", 32'(bus.valid), 32'd0);
      chk("drain_level", 32'(bus.level), 32'd0);
      // Empty pop has no effect
      pop_n(1);
      chk("empty_pop_level", 32'(bus.level), 32'd0);
      chk("empty_pop_valid", 32'(bus.valid), 32'd0);
      chk("empty_pop_data", 32'(bus.data), 32'd0);

      // Simultaneous push and pop at level 2
      do_reset();
      bus.en = 1'b1;
      wait_level(2, 200, "sim_level2");
      exp_q.push_back(2);
      exp_q.push_back(3);
      exp_q.push_back(5);
      wait_ready(1'b0, 20, "sim_search_start");
      wait_ready(1'b1, 30, "sim_search_done");
      bus.en = 1'b0;
      pop_n(1);
      chk("sim_level_kept", 32'(bus.level), 32'd2);
      chk("sim_head", 32'(bus.data), 32'd3);
      pop_n(2);
      chk("sim_drained", 32'(bus.valid), 32'd0);

      // Error on the third search
      err_on = 3;
      do_reset();
      bus.en = 1'b1;
      begin
         int k = 0;
         while (bus.err !== 1'b1 && k < 300) begin
            cyc();
            k++;
         end
      end
      chk("err_set", 32'(bus.err), 32'd1);
      chk("err_level", 32'(bus.level), 32'd2);
      repeat (50) cyc();
      chk("err_go_cnt", 32'(go_cnt), 32'd3);
      exp_q.push_back(2);
      exp_q.push_back(3);
      pop_n(2);
      chk("err_drained", 32'(bus.valid), 32'd0);
      chk("err_sticky", 32'(bus.err), 32'd1);
      err_on = 0;

      // Dropping en during WAIT keeps the in-flight result
      do_reset();
      bus.en = 1'b1;
      wait_ready(1'b0, 20, "en_search_start");
      cyc();
      cyc();
      bus.en = 1'b0;
      wait_level(1, 40, "en_level");
      chk("en_data", 32'(bus.data), 32'd2);
      repeat (60) cyc();
      chk("en_go_cnt", 32'(go_cnt), 32'd1);
      chk("en_level_hold", 32'(bus.level), 32'd1);
      exp_q.push_back(2);
      pop_n(1);

      // Reset during WAIT clears everything asynchronously
      do_reset();
      bus.en = 1'b1;
      wait_level(1, 40, "rw_level");
      wait_ready(1'b0, 20, "rw_search_start");
      cyc();
      cyc();
      cyc();
      rst = 1'b1;
      #2;
      chk("rw_pg_go", 32'(bus.pg_go), 32'd0);
      chk("rw_valid", 32'(bus.valid), 32'd0);
      chk("rw_data",  32'(bus.data),  32'd0);
      chk("rw_level", 32'(bus.level), 32'd0);
      do_reset();
      bus.en = 1'b1;
      exp_q.push_back(2);
      wait_level(1, 40, "rw_first_level");
      chk("rw_first_data", 32'(bus.data), 32'd2);
      bus.en = 1'b0;
      pop_n(1);

      cyc();
      chk("sb_all_consumed", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end
endmodule
